// File: rtl/seq_mac.sv
// seq_mac: sequential shift-and-add multiply(-accumulate), signed/unsigned per transaction.
// Latency: acceptance edge E0, WIDTH RUN edges, result and o_out_valid on edge E(WIDTH+1).
// Backpressure: o_in_ready only in IDLE; i_in_valid while busy is ignored, not queued.
// Build option: define MAC_ACCUM_EN to enable the accumulator adder and overflow flag.
module seq_mac #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH+8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  input  logic                 i_is_signed,
  input  logic                 i_acc_en,
  input  logic                 i_acc_clr,
  output logic [ACC_WIDTH-1:0] o_out,
  output logic                 o_out_valid,
  output logic                 o_busy,
  output logic                 o_overflow
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_accept;

  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_pp;
  logic [CW-1:0]        r_cnt;
  logic                 r_sign;
  logic [ACC_WIDTH-1:0] r_out;
  logic                 r_out_valid;

  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [WIDTH:0]       w_add;
  logic [ACC_WIDTH-1:0] w_p_mag;
  logic [ACC_WIDTH-1:0] w_p;

  // Magnitudes of the operands; -2^(WIDTH-1) negates to itself, which reads correctly as unsigned.
  assign w_a_mag = (i_is_signed && i_a[WIDTH-1]) ? (~i_a + WIDTH'(1)) : i_a;
  assign w_b_mag = (i_is_signed && i_b[WIDTH-1]) ? (~i_b + WIDTH'(1)) : i_b;

  // One shift-and-add step: conditional add into the upper half, carry kept as the new MSB.
  assign w_add   = {1'b0, r_pp[2*WIDTH-1:WIDTH]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);

  // Magnitude product fits below the sign bit, so negating after zero-extension equals sign-extension.
  assign w_p_mag = ACC_WIDTH'(r_pp);
  assign w_p     = r_sign ? (~w_p_mag + ACC_WIDTH'(1)) : w_p_mag;

`ifdef MAC_ACCUM_EN
  logic                 r_is_signed;
  logic                 r_acc_en;
  logic                 r_acc_clr;
  logic                 r_overflow;
  logic [ACC_WIDTH:0]   w_sum;
  logic                 w_ovf;

  // Accumulator add; overflow is the carry (unsigned) or a same-sign add changing sign (signed).
  assign w_sum = {1'b0, r_out} + {1'b0, w_p};
  assign w_ovf = r_is_signed
               ? ((r_out[ACC_WIDTH-1] == w_p[ACC_WIDTH-1]) && (w_sum[ACC_WIDTH-1] != r_out[ACC_WIDTH-1]))
               : w_sum[ACC_WIDTH];
  assign o_overflow = r_overflow;

  // Capture per-transaction accumulate controls at acceptance; reset clears the sticky flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_is_signed <= 1'b0;
      r_acc_en    <= 1'b0;
      r_acc_clr   <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (i_enable) begin
      if (w_accept) begin
        r_is_signed <= i_is_signed;
        r_acc_en    <= i_acc_en;
        r_acc_clr   <= i_acc_clr;
      end
      if (r_state == S_DONE) begin
        if (r_acc_en && !r_acc_clr) r_overflow <= r_overflow | w_ovf;
        else                        r_overflow <= 1'b0;
      end
    end
  end
`else
  logic w_unused;
  assign w_unused   = ^{i_acc_en, i_acc_clr};
  assign o_overflow = 1'b0;
`endif

  // Next-state decode: accept in IDLE, leave RUN after WIDTH steps, DONE lasts one enabled edge.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: if (i_in_valid && i_enable) begin
        w_accept    = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN:  if (i_enable && (r_cnt == CW'(WIDTH-1))) w_state_nxt = S_DONE;
      S_DONE: if (i_enable) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; disabled cycles freeze the FSM.
  always_ff @(posedge i_clk) begin
    if (i_rst)         r_state <= S_IDLE;
    else if (i_enable) r_state <= w_state_nxt;
  end

  // Datapath: capture at acceptance, iterate in RUN, publish in DONE.
  // o_out_valid is a pulse and drops on the following edge even if enable is low.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_pp        <= '0;
      r_cnt       <= '0;
      r_sign      <= 1'b0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (i_enable) begin
        case (r_state)
          S_IDLE: if (w_accept) begin
            r_mcand  <= w_a_mag;
            r_mplier <= w_b_mag;
            r_sign   <= i_is_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_pp     <= '0;
            r_cnt    <= '0;
          end
          S_RUN: begin
            r_pp     <= {w_add, r_pp[WIDTH-1:1]};
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
          end
          S_DONE: begin
`ifdef MAC_ACCUM_EN
            if (r_acc_en && !r_acc_clr) r_out <= w_sum[ACC_WIDTH-1:0];
            else                        r_out <= w_p;
`else
            r_out <= w_p;
`endif
            r_out_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_out       = r_out;
  assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_seq_mac.sv
// Directed bench for seq_mac: two instances (WIDTH=4 with 12-bit and 8-bit accumulators) share stimulus.
// Expectations are hand-computed; accumulate results depend on whether MAC_ACCUM_EN is defined.
// Outputs are sampled 1 time unit after the rising edge; inputs change on the falling edge or after sampling.
module tb_seq_mac;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        in_valid;
  logic [3:0]  a;
  logic [3:0]  b;
  logic        is_signed;
  logic        acc_en;
  logic        acc_clr;

  logic        in_ready;
  logic [11:0] out;
  logic        out_valid;
  logic        busy;
  logic        overflow;

  logic        in_ready8;
  logic [7:0]  out8;
  logic        out_valid8;
  logic        busy8;
  logic        overflow8;

  int total = 0;
  int fails = 0;
  int lat;
  int bcnt;
  int vcnt;

  seq_mac #(.WIDTH(4), .ACC_WIDTH(12)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_a(a), .i_b(b), .i_is_signed(is_signed), .i_acc_en(acc_en), .i_acc_clr(acc_clr),
    .o_out(out), .o_out_valid(out_valid), .o_busy(busy), .o_overflow(overflow)
  );

  seq_mac #(.WIDTH(4), .ACC_WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_in_valid(in_valid), .o_in_ready(in_ready8),
    .i_a(a), .i_b(b), .i_is_signed(is_signed), .i_acc_en(acc_en), .i_acc_clr(acc_clr),
    .o_out(out8), .o_out_valid(out_valid8), .o_busy(busy8), .o_overflow(overflow8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction: present at a falling edge, accepted at E0, then wait for o_out_valid.
  // lat = index of the edge after E0 that raised o_out_valid (-1 if none within budget).
  // bc = busy samples high after E0 onward. gap_at > 0 drops enable for 3 edges after edge gap_at.
  task automatic do_txn(input logic [3:0] ta, input logic [3:0] tb, input logic ts,
                        input logic ten, input logic tclr, input logic hold, input int gap_at,
                        output int tl, output int bc);
    @(negedge clk);
    a = ta; b = tb; is_signed = ts; acc_en = ten; acc_clr = tclr; in_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
    tl = -1;
    bc = (busy === 1'b1) ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (gap_at > 0 && k == gap_at)     enable = 1'b0;
      if (gap_at > 0 && k == gap_at + 3) enable = 1'b1;
      if (out_valid === 1'b1) begin
        tl = k;
        break;
      end
      if (busy === 1'b1) bc++;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; in_valid = 1'b0;
    a = '0; b = '0; is_signed = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out",       32'(out),       32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_in_ready",  32'(in_ready),  32'h1);
    check("rst_overflow",  32'(overflow),  32'h0);
    rst = 1'b0;

    // 3*3 unsigned, restart accumulator
    do_txn(4'd3, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 0, lat, bcnt);
    check("u3x3_out",  32'(out),  32'h9);
    check("u3x3_lat",  32'(lat),  32'd5);
    check("u3x3_busy", 32'(bcnt), 32'd5);
    check("u3x3_ready_with_valid", 32'(in_ready), 32'h1);

    // 15*11 then accumulate 7*4
    do_txn(4'd15, 4'd11, 1'b0, 1'b0, 1'b1, 1'b0, 0, lat, bcnt);
    check("u15x11_out", 32'(out), 32'd165);
    do_txn(4'd7, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 0, lat, bcnt);
`ifdef MAC_ACCUM_EN
    check("acc_7x4_out", 32'(out), 32'd193);
`else
    check("acc_7x4_out", 32'(out), 32'd28);
`endif
    check("acc_7x4_ovf", 32'(overflow), 32'h0);

    // Signed products
    do_txn(4'h8, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 0, lat, bcnt);
    check("s_m8x7",  32'(out), 32'hFC8);
    do_txn(4'h8, 4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 0, lat, bcnt);
    check("s_m8xm8", 32'(out), 32'h040);
    do_txn(4'h7, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 0, lat, bcnt);
    check("s_7xm1",  32'(out), 32'hFF9);

    // 9*7 with in_valid held through RUN and enable low for 3 edges
    do_txn(4'd9, 4'd7, 1'b0, 1'b0, 1'b1, 1'b1, 2, lat, bcnt);
    check("gap_out", 32'(out), 32'd63);
    check("gap_lat", 32'(lat), 32'd8);
    @(posedge clk);
    #1;
    check("gap_idle_after", 32'(busy), 32'h0);

    // 8-bit accumulator overflow on the second instance
    do_txn(4'd15, 4'd15, 1'b0, 1'b0, 1'b1, 1'b0, 0, lat, bcnt);
    check("a8_225", 32'(out8), 32'd225);
    do_txn(4'd15, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0, 0, lat, bcnt);
`ifdef MAC_ACCUM_EN
    check("a8_acc_out", 32'(out8),      32'd194);
    check("a8_acc_ovf", 32'(overflow8), 32'h1);
`else
    check("a8_acc_out", 32'(out8),      32'd225);
    check("a8_acc_ovf", 32'(overflow8), 32'h0);
`endif
    do_txn(4'd2, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0, 0, lat, bcnt);
    check("a8_clr_out", 32'(out8),      32'd4);
    check("a8_clr_ovf", 32'(overflow8), 32'h0);

    // Reset on the 2nd RUN edge aborts the transaction
    @(negedge clk);
    a = 4'd15; b = 4'd15; is_signed = 1'b0; acc_en = 1'b0; acc_clr = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_out",       32'(out),       32'h0);
    check("abort_out_valid", 32'(out_valid), 32'h0);
    check("abort_busy",      32'(busy),      32'h0);
    check("abort_in_ready",  32'(in_ready),  32'h1);
    rst = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) vcnt++;
    end
    check("abort_no_valid", 32'(vcnt), 32'd0);
    do_txn(4'd5, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 0, lat, bcnt);
    check("post_rst_out", 32'(out), 32'd25);
    check("post_rst_lat", 32'(lat), 32'd5);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/seq_mac.md
# seq_mac

Parametrised sequential shift-and-add multiply-accumulate unit for the ML datapath; successor to the fixed 4x4 `multiplier`. Accepts one operand pair per transaction over a valid/ready handshake. Computes the product iteratively in WIDTH cycles, with signed or unsigned mode selected per transaction. Optionally accumulates results into a wide register for dot-product work.

## Interface
- WIDTH, 8: operand width in bits, ≥2.
- ACC_WIDTH, 2*WIDTH+8: accumulator/output width; must be ≥ 2*WIDTH.
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  global clock enable; when low, all state, counters and outputs hold.
- in_valid  in  1  operand pair presented.
- in_ready  out  1  block can accept; equals (state==IDLE).
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- is_signed  in  1  two's-complement operands when 1; sampled at acceptance.
- acc_en  in  1  add product to accumulator when 1; sampled at acceptance.
- acc_clr  in  1  restart accumulator with this product, discarding the prior total; sampled at acceptance.
- out  out  ACC_WIDTH  result/accumulator value; held between results.
- out_valid  out  1  one-cycle pulse, out updated.
- busy  out  1  high in RUN and DONE.
- overflow  out  1  sticky accumulator overflow flag.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: acceptance = in_valid & in_ready & enable at a clock edge.
  - On acceptance, capture |a| and |b|; in signed mode also capture sign = a[MSB]^b[MSB]; in unsigned mode use raw values.
  - Also capture is_signed, acc_en, acc_clr; clear the 2*WIDTH partial product and the counter; go to RUN.
- RUN: each enabled edge, if the multiplier LSB is 1, add the multiplicand into the upper half of the partial product. Shift right one bit and increment the counter. After WIDTH steps, go to DONE.
- DONE: one enabled edge.
  - p = partial product, negated if sign; extended to ACC_WIDTH (sign-extended if signed, zero-extended if unsigned).
  - If acc_en & !acc_clr: out <= out + p, and update overflow.
  - Otherwise: out <= p and overflow <= 0.
  - Assert out_valid for one cycle and go to IDLE.
- Overflow:
  - Unsigned: carry out of the ACC_WIDTH add.
  - Signed: operands of equal sign produce a result of differing sign.
  - Sticky until acc_clr transaction, non-accumulate transaction, or rst.
- Signed -2^(WIDTH-1) has a magnitude of 2^(WIDTH-1), which fits in WIDTH unsigned bits; no special case.
- in_valid while busy: ignored, not queued; in_ready low.
- Operands a/b may change freely after acceptance.

## Timing
- Reset values: state IDLE, out 0, out_valid 0, busy 0, in_ready 1, overflow 0, counter 0.
- rst mid-RUN or mid-DONE: transaction aborted, all reset values restored on that edge, no out_valid.
- Acceptance edge E0. RUN occupies edges E1..E_WIDTH. The DONE edge is E_(WIDTH+1), which raises out_valid and updates out.
- in_ready is high in the cycle after E_(WIDTH+1); the next acceptance can occur at E_(WIDTH+2). Throughput is 1 result per WIDTH+2 cycles.
- enable low for N cycles during RUN or DONE delays out_valid by exactly N cycles; the result is unchanged.
- out_valid is never high for more than one cycle and never coincides with in_ready low.

## Configuration
- MAC_ACCUM_EN defined: accumulate path, acc_en/acc_clr and overflow behave as above.
- MAC_ACCUM_EN undefined: no accumulator adder.
  - acc_en and acc_clr are ignored and overflow is tied 0.
  - Every DONE loads out <= p.
  - Ports are unchanged.

## Test plan
- WIDTH=4, ACC_WIDTH=12, unsigned, accept 3*3 with acc_clr=1 -> out=9, out_valid on the 5th edge after acceptance, busy high for 5 cycles.
- Unsigned 15*11 with acc_clr=1, then 7*4 with acc_en=1 -> out=165, then 193; overflow=0.
- Signed: -8*7 -> out=12'hFC8 (-56); -8*-8 -> out=64; 7*-1 -> 12'hFF9.
- 9*7, enable low for 3 cycles mid-RUN -> out=63, out_valid on the 8th edge after acceptance; in_valid held high during RUN is not accepted.
- WIDTH=4, ACC_WIDTH=8, unsigned 15*15 with acc_clr, then 15*15 with acc_en -> out=225, then 194 with overflow=1. A following acc_clr transaction 2*2 -> out=4, overflow=0.
- rst at the 2nd RUN edge of 15*15 -> outputs at reset values, no out_valid. A following 5*5 -> out=25 with normal latency.
- Build without MAC_ACCUM_EN: 3*3, then 2*2 with acc_en=1 -> out=9, then 4; overflow stays 0.
